// File: rtl/pps_memory_hs_pkg.sv
// Shared definitions for the handshaked MEM stage.
// Holds the memop type codes, the FSM state encoding, the decoded access kind
// and small helpers for lane width and type decoding.
package pps_memory_hs_pkg;

  // Memop type codes as presented on MEM_memop_type_in.
  localparam int unsigned tMEM_OP_NULL   = 0;
  localparam int unsigned tMEM_OP_WORD   = 1;
  localparam int unsigned tMEM_OP_HWORD  = 2;
  localparam int unsigned tMEM_OP_HWORDU = 3;
  localparam int unsigned tMEM_OP_BYTE   = 4;
  localparam int unsigned tMEM_OP_BYTEU  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  // Access kind after decoding; OpWord must stay the all-zero encoding.
  typedef enum logic [2:0] {
    OpWord,
    OpHalf,
    OpHalfU,
    OpByte,
    OpByteU
  } op_kind_e;

  // Number of address bits that select a byte lane on the data bus.
  function automatic int unsigned lane_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // NULL and any unrecognised code are handled as a full word.
  function automatic op_kind_e decode_op(input logic [31:0] code);
    case (code)
      tMEM_OP_HWORD:  return OpHalf;
      tMEM_OP_HWORDU: return OpHalfU;
      tMEM_OP_BYTE:   return OpByte;
      tMEM_OP_BYTEU:  return OpByteU;
      default:        return OpWord;
    endcase
  endfunction

endpackage

// File: rtl/pps_memory_hs_mem_lane_align.sv
// Combinational lane handling for the MEM stage.
// Store side: byte enables at the target lane and store data replicated
// across every lane of the bus.
// Load side: selects the byte/half/word at the lane and sign- or zero-extends.
// Ports:
//   st_kind, st_lane, st_data -> st_bwe, st_rep   (store path)
//   ld_kind, ld_lane, ld_data -> ld_ext           (load path)
module pps_memory_hs_mem_lane_align
  import pps_memory_hs_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  op_kind_e                         st_kind,
  input  logic [lane_w(DATA_W)-1:0]        st_lane,
  input  logic [31:0]                      st_data,
  output logic [DATA_W/8-1:0]              st_bwe,
  output logic [DATA_W-1:0]                st_rep,
  input  op_kind_e                         ld_kind,
  input  logic [lane_w(DATA_W)-1:0]        ld_lane,
  input  logic [DATA_W-1:0]                ld_data,
  output logic [31:0]                      ld_ext
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] ld_shift;

  always_comb begin
    st_bwe = '0;
    st_rep = '0;
    unique case (st_kind)
      OpByte, OpByteU: begin
        st_bwe = NB'(1) << st_lane;
        st_rep = {(DATA_W / 8){st_data[7:0]}};
      end
      OpHalf, OpHalfU: begin
        st_bwe = NB'(3) << st_lane;
        st_rep = {(DATA_W / 16){st_data[15:0]}};
      end
      default: begin
        st_bwe = NB'(15) << st_lane;
        st_rep = {(DATA_W / 32){st_data}};
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  assign ld_shift = ld_data >> {ld_lane, 3'b000};

  always_comb begin
    ld_ext = '0;
    unique case (ld_kind)
      OpByte:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      OpByteU: ld_ext = {24'b0, ld_shift[7:0]};
      OpHalf:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      OpHalfU: ld_ext = {16'b0, ld_shift[15:0]};
      default: ld_ext = ld_shift[31:0];
    endcase
  end

endmodule

// File: rtl/pps_memory_hs.sv
// Handshaked MEM pipeline stage.
// Accepts a load/store from EX/MEM, drives a req/ack memory port, stalls the
// pipeline until the access completes and produces writeback data.
// Misaligned accesses pulse MEM_addr_exc_out without issuing a request; a
// missing ack after TIMEOUT_CYC request cycles pulses MEM_bus_err_out.
// Ports:
//   clk, rst_n (synchronous, active low)
//   MEM_*_in from EX/MEM   : memop, memwr, memop_type, ALUOut, STData, inst_rd, RegWrite
//   memory port            : MEM_req_out, MEM_Addr_out, MEM_memwr_out, MEM_bwe_out,
//                            MEM_STData_out, MEM_ack_in, MEM_LDData_in
//   to pipeline / MEM/WB   : MEM_stall_out, MEM_MUXOut_out, MEM_inst_rd_out,
//                            MEM_RegWrite_out, MEM_addr_exc_out, MEM_bus_err_out
module pps_memory_hs
  import pps_memory_hs_pkg::*;
#(
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned MEM_OP_TYPE_SIZE = 7,
  parameter int unsigned TIMEOUT_CYC      = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        MEM_memop_in,
  input  logic                        MEM_memwr_in,
  input  logic [MEM_OP_TYPE_SIZE-1:0] MEM_memop_type_in,
  input  logic [31:0]                 MEM_ALUOut_in,
  input  logic [31:0]                 MEM_STData_in,
  input  logic [4:0]                  MEM_inst_rd_in,
  input  logic                        MEM_RegWrite_in,
  output logic                        MEM_req_out,
  output logic [ADDR_W-1:0]           MEM_Addr_out,
  output logic                        MEM_memwr_out,
  output logic [DATA_W/8-1:0]         MEM_bwe_out,
  output logic [DATA_W-1:0]           MEM_STData_out,
  input  logic                        MEM_ack_in,
  input  logic [DATA_W-1:0]           MEM_LDData_in,
  output logic                        MEM_stall_out,
  output logic [31:0]                 MEM_MUXOut_out,
  output logic [4:0]                  MEM_inst_rd_out,
  output logic                        MEM_RegWrite_out,
  output logic                        MEM_addr_exc_out,
  output logic                        MEM_bus_err_out
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = lane_w(DATA_W);
  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e              state_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [NB-1:0]       bwe_q;
  logic [DATA_W-1:0]   st_q;
  op_kind_e            kind_q;
  logic [LANE_W-1:0]   lane_q;
  logic [4:0]          rd_q;
  logic                rw_q;
  logic [31:0]         alu_q;
  logic [31:0]         result_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                bus_err_q;

  op_kind_e            in_kind;
  logic [LANE_W-1:0]   in_lane;
  logic [ADDR_W-1:0]   in_addr;
  logic                misaligned;
  logic                timeout_hit;
  logic [NB-1:0]       st_bwe;
  logic [DATA_W-1:0]   st_rep;
  logic [31:0]         ld_ext;

  logic                stall;
  logic                addr_exc;
  logic [31:0]         mux_out;
  logic [4:0]          rd_out;
  logic                rw_out;

  assign in_kind = decode_op(32'(MEM_memop_type_in));
  assign in_lane = MEM_ALUOut_in[LANE_W-1:0];
  assign in_addr = MEM_ALUOut_in[ADDR_W-1:0];

  assign misaligned = ((in_kind == OpHalf || in_kind == OpHalfU) && in_lane[0]) ||
                      (in_kind == OpWord && in_lane[1:0] != 2'b00);

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  pps_memory_hs_mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .st_kind (in_kind),
    .st_lane (in_lane),
    .st_data (MEM_STData_in),
    .st_bwe  (st_bwe),
    .st_rep  (st_rep),
    .ld_kind (kind_q),
    .ld_lane (lane_q),
    .ld_data (MEM_LDData_in),
    .ld_ext  (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      bwe_q     <= '0;
      st_q      <= '0;
      kind_q    <= OpWord;
      lane_q    <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      alu_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (MEM_memop_in && !misaligned) begin
            state_q <= StReq;
            req_q   <= 1'b1;
            addr_q  <= in_addr & ~ADDR_W'(NB - 1);
            wr_q    <= MEM_memwr_in;
            bwe_q   <= MEM_memwr_in ? st_bwe : '1;
            st_q    <= st_rep;
            kind_q  <= in_kind;
            lane_q  <= in_lane;
            rd_q    <= MEM_inst_rd_in;
            rw_q    <= MEM_RegWrite_in;
            alu_q   <= MEM_ALUOut_in;
            cnt_q   <= '0;
          end
        end
        StReq: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (MEM_ack_in) begin
            result_q <= ld_ext;
            req_q    <= 1'b0;
            state_q  <= StDone;
          end else if (timeout_hit) begin
            result_q  <= '0;
            req_q     <= 1'b0;
            rw_q      <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          // An op presented here waits for the following idle cycle.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stall    = 1'b0;
    addr_exc = 1'b0;
    mux_out  = MEM_ALUOut_in;
    rd_out   = MEM_inst_rd_in;
    rw_out   = MEM_RegWrite_in;
    unique case (state_q)
      StIdle: begin
        if (MEM_memop_in) begin
          rw_out = 1'b0;
          if (misaligned) begin
            addr_exc = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
      end
      StReq: begin
        stall  = 1'b1;
        rw_out = 1'b0;
      end
      StDone: begin
        mux_out = wr_q ? alu_q : result_q;
        rd_out  = rd_q;
        rw_out  = rw_q && !wr_q;
      end
      default: ;
    endcase
    // Keep the pipeline-facing pulses quiet while reset is asserted.
    if (!rst_n) begin
      stall    = 1'b0;
      addr_exc = 1'b0;
    end
  end

  assign MEM_req_out      = req_q;
  assign MEM_Addr_out     = addr_q;
  assign MEM_memwr_out    = wr_q;
  assign MEM_bwe_out      = bwe_q;
  assign MEM_STData_out   = st_q;
  assign MEM_stall_out    = stall;
  assign MEM_MUXOut_out   = mux_out;
  assign MEM_inst_rd_out  = rd_out;
  assign MEM_RegWrite_out = rw_out;
  assign MEM_addr_exc_out = addr_exc;
  assign MEM_bus_err_out  = bus_err_q;

endmodule
